// File: rtl/issue_scoreboard.sv
// Decode-stage register scoreboard: tracks per-register cycles until an in-flight
// result becomes forwardable, stalls dependent readers, and counts stall cycles.
module issue_scoreboard #(
  parameter int NREGS = 16,
  parameter int REGW  = 4,
  parameter int LATW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issuevalid,
  input  logic [REGW-1:0]   idregrs,
  input  logic [REGW-1:0]   idregrt,
  input  logic              idusesrs,
  input  logic              idusesrt,
  input  logic              idregwrite,
  input  logic [REGW-1:0]   idregrd,
  input  logic [LATW-1:0]   idlatency,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [NREGS-1:0]  busy,
  output logic [15:0]       stallcount
);

  logic [LATW-1:0]  cnt_q [NREGS];
  logic [LATW-1:0]  cnt_d [NREGS];
  logic [LATW-1:0]  dec_s [NREGS];
  logic             lastvalid_q, lastvalid_d;
  logic [REGW-1:0]  lastrd_q, lastrd_d;
  logic [LATW-1:0]  lastprev_q, lastprev_d;
  logic [15:0]      stallcount_q, stallcount_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic             hit_s, hit_t;
  logic             stall_s, issue_s, reserve_s;
  logic [LATW-1:0]  new_lat_s;

  // Per-register countdown after this cycle's decrement
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      if (cnt_q[r] != {LATW{1'b0}}) begin
        dec_s[r] = cnt_q[r] - LATW'(1);
      end else begin
        dec_s[r] = {LATW{1'b0}};
      end
    end
  end

  // Hazard detection against pre-reservation counts; flush overrides everything
  always_comb begin
    hit_s     = idusesrs & (cnt_q[idregrs] != {LATW{1'b0}});
    hit_t     = idusesrt & (cnt_q[idregrt] != {LATW{1'b0}});
    stall_s   = issuevalid & ~flush & (hit_s | hit_t);
    issue_s   = issuevalid & ~flush & ~stall_s;
    reserve_s = issue_s & idregwrite & (idregrd != {REGW{1'b0}});
    if (idlatency == {LATW{1'b0}}) begin
      new_lat_s = {LATW{1'b0}};
    end else begin
      new_lat_s = idlatency - LATW'(1);
    end
  end

  // Next-state for countdowns: flush restore, or WAW-safe reservation
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = dec_s[r];
    end
    if (flush) begin
      if (lastvalid_q) begin
        // Undo the squashed reservation by resuming the older writer's countdown
        if (lastprev_q == {LATW{1'b0}}) begin
          cnt_d[lastrd_q] = {LATW{1'b0}};
        end else begin
          cnt_d[lastrd_q] = lastprev_q - LATW'(1);
        end
      end else begin
        cnt_d[lastrd_q] = dec_s[lastrd_q];
      end
    end else if (reserve_s) begin
      if (new_lat_s > dec_s[idregrd]) begin
        cnt_d[idregrd] = new_lat_s;
      end else begin
        cnt_d[idregrd] = dec_s[idregrd];
      end
    end else begin
      cnt_d[idregrd] = dec_s[idregrd];
    end
    lastvalid_d = reserve_s;
    lastrd_d    = idregrd;
    lastprev_d  = dec_s[idregrd];
  end

  // Busy vector and saturating stall counter next-state
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_d[r] = (cnt_d[r] != {LATW{1'b0}});
    end
    if (stall_s && (stallcount_q != 16'hFFFF)) begin
      stallcount_d = stallcount_q + 16'd1;
    end else begin
      stallcount_d = stallcount_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= {LATW{1'b0}};
      end
      lastvalid_q  <= 1'b0;
      lastrd_q     <= {REGW{1'b0}};
      lastprev_q   <= {LATW{1'b0}};
      stallcount_q <= 16'd0;
      busy_q       <= {NREGS{1'b0}};
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      lastvalid_q  <= lastvalid_d;
      lastrd_q     <= lastrd_d;
      lastprev_q   <= lastprev_d;
      stallcount_q <= stallcount_d;
      busy_q       <= busy_d;
    end
  end

  assign stall      = stall_s;
  assign issue      = issue_s;
  assign busy       = busy_q;
  assign stallcount = stallcount_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: absolute ready-time reference model, directed scenarios
// with literal expectations, randomized traffic, and stall-counter saturation.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issuevalid;
  logic [3:0]  idregrs, idregrt, idregrd;
  logic        idusesrs, idusesrt, idregwrite;
  logic [2:0]  idlatency;
  logic        flush;
  logic        stall, issue;
  logic [15:0] busy;
  logic [15:0] stallcount;

  issue_scoreboard #(.NREGS(16), .REGW(4), .LATW(3)) dut (
    .clk(clk), .rst(rst), .issuevalid(issuevalid),
    .idregrs(idregrs), .idregrt(idregrt), .idusesrs(idusesrs), .idusesrt(idusesrt),
    .idregwrite(idregwrite), .idregrd(idregrd), .idlatency(idlatency), .flush(flush),
    .stall(stall), .issue(issue), .busy(busy), .stallcount(stallcount)
  );

  always #5 clk = ~clk;

  // Model: ready[r] is the first absolute cycle in which a reader of r may issue
  longint t;
  longint ready [16];
  longint saved_ready;
  int     saved_rd;
  bit     saved_valid;
  int     sc;
  int     checks = 0;
  int     errors = 0;
  bit     obs_stall, obs_issue;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
    end
  endtask

  task automatic set_in(bit v, int a, bit ua, int b, bit ub, bit w, int d, int lat, bit f);
    rst        = 1'b0;
    issuevalid = v;
    idregrs    = 4'(a);
    idusesrs   = ua;
    idregrt    = 4'(b);
    idusesrt   = ub;
    idregwrite = w;
    idregrd    = 4'(d);
    idlatency  = 3'(lat);
    flush      = f;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs
  task automatic cycle();
    bit hs, ht, es, ei, nv;
    longint lat;
    logic [15:0] eb;
    #4;
    hs = idusesrs && (ready[idregrs] > t);
    ht = idusesrt && (ready[idregrt] > t);
    es = issuevalid && !flush && (hs || ht);
    ei = issuevalid && !flush && !es;
    chk("stall", stall, es);
    chk("issue", issue, ei);
    obs_stall = stall;
    obs_issue = issue;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 16; r++) ready[r] = t + 1;
      saved_valid = 0;
      sc = 0;
    end else begin
      nv = 0;
      if (flush) begin
        if (saved_valid) ready[saved_rd] = saved_ready;
      end else if (ei && idregwrite && idregrd != 4'd0) begin
        lat = (idlatency == 3'd0) ? 1 : longint'(idlatency);
        saved_ready = ready[idregrd];
        saved_rd = idregrd;
        nv = 1;
        if (t + lat > ready[idregrd]) ready[idregrd] = t + lat;
      end
      saved_valid = nv;
      if (es && sc < 65535) sc++;
    end
    t++;
    #1;
    for (int r = 0; r < 16; r++) eb[r] = (ready[r] > t);
    chk("busy", busy, eb);
    chk("stallcount", stallcount, sc);
  endtask

  task automatic reader(int r, int exp_stalls, string name);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      set_in(1, r, 1, 0, 0, 0, 0, 1, 0);
      cycle();
      if (obs_issue) done = 1;
      else if (obs_stall) n++;
    end
    chk({name, "_stalls"}, n, exp_stalls);
    chk({name, "_issued"}, done, 1);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int sc0;

  initial begin
    t = 0;
    sc = 0;
    saved_valid = 0;
    for (int r = 0; r < 16; r++) ready[r] = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_stallcount", stallcount, 0);

    // Load-use: one bubble
    set_in(1, 0, 0, 0, 0, 1, 3, 2, 0);
    cycle();
    chk("load_busy3", busy[3], 1);
    reader(3, 1, "load_use");
    chk("load_busy3_clear", busy[3], 0);

    // ALU chain: no stall
    set_in(1, 0, 0, 0, 0, 1, 4, 1, 0);
    cycle();
    chk("alu_busy", busy, 0);
    reader(4, 0, "alu_chain");

    // Multiply latency 5: four bubbles, independent reader free
    set_in(1, 0, 0, 0, 0, 1, 5, 5, 0);
    cycle();
    sc0 = stallcount;
    reader(5, 4, "mul5");
    chk("mul5_stallcount_delta", stallcount - sc0, 4);
    set_in(1, 0, 0, 0, 0, 1, 5, 5, 0);
    cycle();
    reader(9, 0, "independent");

    // r0 is never reserved
    do_reset();
    set_in(1, 0, 0, 0, 0, 1, 0, 2, 0);
    cycle();
    reader(0, 0, "r0");

    // Flush squashes the load reservation
    set_in(1, 0, 0, 0, 0, 1, 3, 2, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("flush_busy3", busy[3], 0);
    reader(3, 0, "after_flush");

    // WAW keeps the longer countdown; same-cycle read/write of free reg
    set_in(1, 0, 0, 0, 0, 1, 6, 6, 0);
    cycle();
    set_in(1, 0, 0, 0, 0, 1, 6, 2, 0);
    cycle();
    reader(6, 4, "waw");
    set_in(1, 7, 1, 0, 0, 1, 7, 2, 0);
    cycle();
    chk("rw_same_stall", obs_stall, 0);
    chk("rw_same_issue", obs_issue, 1);

    // Reset mid-countdown
    set_in(1, 0, 0, 0, 0, 1, 5, 7, 0);
    cycle();
    reader(1, 0, "pre_rst");
    do_reset();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_stallcount", stallcount, 0);
    reader(5, 0, "post_rst");

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cycle();
    end

    // Saturation: self-dependent lat-7 writer stalls six of every seven cycles
    do_reset();
    set_in(1, 5, 1, 0, 0, 1, 5, 7, 0);
    for (int k = 0; k < 76510; k++) cycle();
    chk("stallcount_saturated", stallcount, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
